// File: rtl/eth_tx_payload_fifo.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_payload_fifo
// Description : Frame-aware payload byte FIFO feeding the Ethernet TX framer.
//               Commits whole frames only; oversize/overflowed frames dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_tx_payload_fifo #(
    parameter int ADDR_W      = 11,
    parameter int LEN_FIFO_W  = 2,
    parameter int MAX_PAYLOAD = 1500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  s_drop,
    output logic                  m_frame_ready,
    output logic [15:0]           m_frame_len,
    input  logic                  m_rd_en,
    output logic [7:0]            m_data,
    output logic                  m_data_valid,
    output logic                  m_frame_done,
    output logic [LEN_FIFO_W:0]   frame_count
);

    localparam int                  c_DEPTH     = 1 << ADDR_W;
    localparam int                  c_LF_DEPTH  = 1 << LEN_FIFO_W;
    localparam logic [ADDR_W:0]     c_FULL_DIFF = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [LEN_FIFO_W:0] c_LF_FULL   = {1'b1, {LEN_FIFO_W{1'b0}}};
    localparam logic [15:0]         c_MAX_LEN   = 16'(MAX_PAYLOAD);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_WRITE   = 2'd1;
    localparam logic [1:0] c_DISCARD = 2'd2;

    generate
        if (MAX_PAYLOAD >= c_DEPTH) begin : g_bad_max_payload
            $error("MAX_PAYLOAD must be smaller than the data RAM capacity");
        end
    endgenerate

    logic [7:0]            r_ram [0:c_DEPTH-1];
    logic [15:0]           r_len_mem [0:c_LF_DEPTH-1];
    logic [ADDR_W:0]       r_wr_ptr;
    logic [ADDR_W:0]       r_commit_ptr;
    logic [ADDR_W:0]       r_rd_ptr;
    logic [LEN_FIFO_W:0]   r_lf_wr_ptr;
    logic [LEN_FIFO_W:0]   r_lf_rd_ptr;
    logic [15:0]           r_wr_cnt;
    logic [15:0]           r_rd_cnt;
    logic [1:0]            r_state;
    logic                  r_drop;
    logic [7:0]            r_data;
    logic                  r_data_valid;
    logic                  r_frame_done;

    logic [LEN_FIFO_W:0]   w_lf_count;
    logic                  w_lf_full;
    logic                  w_data_full;
    logic                  w_accept;
    logic [15:0]           w_head_len;
    logic                  w_frame_ready;
    logic                  w_rd_accept;
    logic                  w_rd_last;
    logic                  w_store;
    logic                  w_commit;
    logic                  w_drop;
    logic [1:0]            w_state_nxt;
    logic [15:0]           w_wr_cnt_nxt;

    // Fullness uses the working write pointer so an open frame cannot overrun unread data.
    assign w_lf_count    = r_lf_wr_ptr - r_lf_rd_ptr;
    assign w_lf_full     = (w_lf_count == c_LF_FULL);
    assign w_data_full   = ((r_wr_ptr - r_rd_ptr) == c_FULL_DIFF);
    assign s_ready       = (r_state == c_IDLE) ? !w_lf_full : 1'b1;
    assign w_accept      = s_valid & s_ready;
    assign w_head_len    = r_len_mem[r_lf_rd_ptr[LEN_FIFO_W-1:0]];
    assign w_frame_ready = (w_lf_count != '0);
    assign w_rd_accept   = m_rd_en & w_frame_ready & (r_rd_cnt < w_head_len);
    assign w_rd_last     = w_rd_accept & ((r_rd_cnt + 16'd1) == w_head_len);

    always_comb begin
        w_store      = 1'b0;
        w_commit     = 1'b0;
        w_drop       = 1'b0;
        w_state_nxt  = r_state;
        w_wr_cnt_nxt = r_wr_cnt;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    if (w_data_full) begin
                        if (s_last) w_drop = 1'b1;
                        else        w_state_nxt = c_DISCARD;
                    end else begin
                        w_store      = 1'b1;
                        w_wr_cnt_nxt = 16'd1;
                        if (s_last) w_commit = 1'b1;
                        else        w_state_nxt = c_WRITE;
                    end
                end
            end
            c_WRITE: begin
                if (w_accept) begin
                    if (w_data_full || (r_wr_cnt == c_MAX_LEN)) begin
                        if (s_last) begin
                            w_drop      = 1'b1;
                            w_state_nxt = c_IDLE;
                        end else begin
                            w_state_nxt = c_DISCARD;
                        end
                    end else begin
                        w_store      = 1'b1;
                        w_wr_cnt_nxt = r_wr_cnt + 16'd1;
                        if (s_last) begin
                            w_commit    = 1'b1;
                            w_state_nxt = c_IDLE;
                        end
                    end
                end
            end
            c_DISCARD: begin
                if (w_accept && s_last) begin
                    w_drop      = 1'b1;
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_store) r_ram[r_wr_ptr[ADDR_W-1:0]] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_wr_cnt     <= '0;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_lf_wr_ptr  <= '0;
            r_drop       <= 1'b0;
            for (int i = 0; i < c_LF_DEPTH; i++) r_len_mem[i] <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_cnt <= w_wr_cnt_nxt;
            r_drop   <= w_drop;
            if (w_store) r_wr_ptr <= r_wr_ptr + 1'b1;
            // A dropped frame rewinds to the last committed position.
            if (w_drop)  r_wr_ptr <= r_commit_ptr;
            if (w_commit) begin
                r_commit_ptr                              <= r_wr_ptr + 1'b1;
                r_len_mem[r_lf_wr_ptr[LEN_FIFO_W-1:0]]   <= w_wr_cnt_nxt;
                r_lf_wr_ptr                               <= r_lf_wr_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr     <= '0;
            r_rd_cnt     <= '0;
            r_lf_rd_ptr  <= '0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_data_valid <= w_rd_accept;
            r_frame_done <= w_rd_last;
            if (w_rd_accept) begin
                r_data   <= r_ram[r_rd_ptr[ADDR_W-1:0]];
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_rd_cnt <= r_rd_cnt + 16'd1;
            end
            if (w_rd_last) begin
                r_rd_cnt    <= '0;
                r_lf_rd_ptr <= r_lf_rd_ptr + 1'b1;
            end
        end
    end

    assign s_drop        = r_drop;
    assign m_frame_ready = w_frame_ready;
    assign m_frame_len   = w_head_len;
    assign m_data        = r_data;
    assign m_data_valid  = r_data_valid;
    assign m_frame_done  = r_frame_done;
    assign frame_count   = w_lf_count;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_payload_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_tx_payload_fifo
// Description : Scoreboard bench for eth_tx_payload_fifo (default and 64-byte builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_tx_payload_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       m_rd_en = 1'b0;
    logic       sel = 1'b0;

    logic        b_s_ready, b_s_drop, b_frame_ready, b_data_valid, b_frame_done;
    logic [15:0] b_frame_len;
    logic [7:0]  b_data;
    logic [2:0]  b_frame_count;
    logic        t_s_ready, t_s_drop, t_frame_ready, t_data_valid, t_frame_done;
    logic [15:0] t_frame_len;
    logic [7:0]  t_data;
    logic [2:0]  t_frame_count;

    logic        o_ready, o_drop, o_frame_ready, o_data_valid, o_frame_done;
    logic [15:0] o_frame_len;
    logic [7:0]  o_data;
    logic [2:0]  o_count;

    int n_checks = 0;
    int n_errors = 0;
    int drop_cnt = 0;
    logic [8:0]  sb[$];
    logic [15:0] lenq[$];

    always #5 clk = ~clk;

    eth_tx_payload_fifo dut_big (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid & ~sel), .s_last(s_last),
        .s_ready(b_s_ready), .s_drop(b_s_drop), .m_frame_ready(b_frame_ready),
        .m_frame_len(b_frame_len), .m_rd_en(m_rd_en & ~sel), .m_data(b_data),
        .m_data_valid(b_data_valid), .m_frame_done(b_frame_done), .frame_count(b_frame_count)
    );

    eth_tx_payload_fifo #(.ADDR_W(6), .LEN_FIFO_W(2), .MAX_PAYLOAD(60)) dut_small (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid & sel), .s_last(s_last),
        .s_ready(t_s_ready), .s_drop(t_s_drop), .m_frame_ready(t_frame_ready),
        .m_frame_len(t_frame_len), .m_rd_en(m_rd_en & sel), .m_data(t_data),
        .m_data_valid(t_data_valid), .m_frame_done(t_frame_done), .frame_count(t_frame_count)
    );

    assign o_ready       = sel ? t_s_ready     : b_s_ready;
    assign o_drop        = sel ? t_s_drop      : b_s_drop;
    assign o_frame_ready = sel ? t_frame_ready : b_frame_ready;
    assign o_frame_len   = sel ? t_frame_len   : b_frame_len;
    assign o_data        = sel ? t_data        : b_data;
    assign o_data_valid  = sel ? t_data_valid  : b_data_valid;
    assign o_frame_done  = sel ? t_frame_done  : b_frame_done;
    assign o_count       = sel ? t_frame_count : b_frame_count;

    always @(negedge clk) if (o_drop) drop_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Caller sits at a negedge; returns at the negedge after the handshake edge.
    task automatic send(input logic [7:0] d, input logic last);
        int t = 0;
        s_data = d; s_valid = 1'b1; s_last = last;
        while (!o_ready && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) begin
            n_checks++; n_errors++;
            $display("FAIL send_timeout: s_ready=%0b required=1", o_ready);
        end
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic write_frame(input int len, input int base, input bit commit);
        for (int i = 0; i < len; i++) begin
            logic [7:0] d;
            d = 8'(base + i);
            send(d, i == len - 1);
            if (commit) sb.push_back({i == len - 1, d});
        end
        if (commit) lenq.push_back(16'(len));
    endtask

    task automatic read_bytes(input int n);
        logic [8:0] e;
        for (int i = 0; i <= n; i++) begin
            if (i > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (o_data_valid !== 1'b1 || o_data !== e[7:0] || o_frame_done !== e[8]) begin
                    n_errors++;
                    $display("FAIL read_byte[%0d]: valid=%0b data=%02h done=%0b required valid=1 data=%02h done=%0b",
                             i - 1, o_data_valid, o_data, o_frame_done, e[7:0], e[8]);
                end
                if (e[8]) void'(lenq.pop_front());
            end
            m_rd_en = (i < n);
            @(negedge clk);
        end
        n_checks++;
        if (o_data_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL read_idle_valid: m_data_valid=%0b required=0", o_data_valid);
        end
    endtask

    task automatic read_frame();
        int n;
        n = int'(lenq[0]);
        n_checks++;
        if (o_frame_ready !== 1'b1 || o_frame_len !== lenq[0]) begin
            n_errors++;
            $display("FAIL frame_head: ready=%0b len=%0d required ready=1 len=%0d",
                     o_frame_ready, o_frame_len, lenq[0]);
        end
        read_bytes(n);
    endtask

    task automatic check_count(input string nm, input logic [2:0] exp);
        n_checks++;
        if (o_count !== exp) begin
            n_errors++;
            $display("FAIL %s: frame_count=%0d required=%0d", nm, o_count, exp);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        n_checks++;
        if (o_ready !== 1'b1 || o_drop !== 1'b0 || o_frame_ready !== 1'b0 || o_frame_len !== 16'd0 ||
            o_data !== 8'd0 || o_data_valid !== 1'b0 || o_frame_done !== 1'b0 || o_count !== 3'd0) begin
            n_errors++;
            $display("FAIL %s: ready=%0b drop=%0b fr=%0b len=%0d data=%02h dv=%0b done=%0b cnt=%0d required 1 0 0 0 00 0 0 0",
                     nm, o_ready, o_drop, o_frame_ready, o_frame_len, o_data, o_data_valid, o_frame_done, o_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sel = 1'b0; check_reset_outputs("reset_big");
        sel = 1'b1; check_reset_outputs("reset_small");
        sel = 1'b0;
    endtask

    task automatic test_basic();
        write_frame(46, 8'h00, 1);
        check_count("basic_count", 3'd1);
        read_frame();
        n_checks++;
        if (o_frame_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_drained: m_frame_ready=%0b required=0", o_frame_ready);
        end
    endtask

    task automatic test_single();
        write_frame(1, 8'hA5, 1);
        read_frame();
        check_count("single_count", 3'd0);
    endtask

    task automatic test_too_long();
        int d0;
        d0 = drop_cnt;
        write_frame(1501, 8'h10, 0);
        n_checks++;
        if (o_drop !== 1'b1) begin
            n_errors++;
            $display("FAIL long_drop_pulse: s_drop=%0b required=1", o_drop);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (drop_cnt - d0 !== 1) begin
            n_errors++;
            $display("FAIL long_drop_once: pulses=%0d required=1", drop_cnt - d0);
        end
        check_count("long_count", 3'd0);
        write_frame(60, 8'h40, 1);
        read_frame();
    endtask

    task automatic test_queue_full();
        for (int f = 0; f < 4; f++) write_frame(10, 8'h20 * f, 1);
        check_count("qfull_count", 3'd4);
        n_checks++;
        if (o_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL qfull_ready: s_ready=%0b required=0", o_ready);
        end
        read_frame();
        n_checks++;
        if (o_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL qfull_reopen: s_ready=%0b required=1", o_ready);
        end
        write_frame(10, 8'hE0, 1);
        check_count("qfull_refill", 3'd4);
        for (int f = 0; f < 4; f++) read_frame();
        check_count("qfull_drain", 3'd0);
    endtask

    task automatic test_back_to_back();
        write_frame(5, 8'h70, 1);
        write_frame(7, 8'h90, 1);
        check_count("b2b_count", 3'd2);
        read_bytes(12);
        check_count("b2b_drain", 3'd0);
    endtask

    task automatic test_wrap_overflow();
        int d0;
        sel = 1'b1;
        @(negedge clk);
        write_frame(40, 8'h00, 1);
        read_frame();
        write_frame(50, 8'h80, 1);
        read_frame();
        write_frame(30, 8'h33, 1);
        d0 = drop_cnt;
        write_frame(70, 8'hC0, 0);
        n_checks++;
        if (o_drop !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_drop_pulse: s_drop=%0b required=1", o_drop);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (drop_cnt - d0 !== 1) begin
            n_errors++;
            $display("FAIL ovf_drop_once: pulses=%0d required=1", drop_cnt - d0);
        end
        check_count("ovf_count", 3'd1);
        read_frame();
        write_frame(20, 8'h55, 1);
        read_frame();
        sel = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int d0;
        write_frame(12, 8'h30, 1);
        for (int i = 0; i < 20; i++) send(8'(8'h80 + i), 1'b0);
        read_bytes(3);
        d0 = drop_cnt;
        rst = 1'b1; m_rd_en = 1'b1; s_valid = 1'b1; s_data = 8'hFF;
        repeat (2) @(negedge clk);
        rst = 1'b0; m_rd_en = 1'b0; s_valid = 1'b0;
        sb.delete(); lenq.delete();
        @(negedge clk);
        check_reset_outputs("midreset_outputs");
        @(negedge clk);
        n_checks++;
        if (drop_cnt !== d0) begin
            n_errors++;
            $display("FAIL midreset_no_drop: pulses=%0d required=0", drop_cnt - d0);
        end
        write_frame(8, 8'hC0, 1);
        read_frame();
        check_count("midreset_final", 3'd0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_too_long();
        test_queue_full();
        test_back_to_back();
        test_wrap_overflow();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
